// File: rtl/genius_button_decoder.sv
// Genius colour-button conditioner: 2-FF sync, debounce, multi-press reject, one strobe per clean press.
// Strobe appears DEBOUNCE_CYCLES+2 edges after the raw press is first sampled; no back-pressure.
`timescale 1ns/1ps
module genius_button_decoder #(
   parameter int COLOR_CODEFY_W  = 2,
   parameter int DEBOUNCE_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      button_color_green,
   input  logic                      button_color_red,
   input  logic                      button_color_blue,
   input  logic                      button_color_yellow,
   input  logic                      enable,
   output logic                      color_valid,
   output logic [COLOR_CODEFY_W-1:0] color_code,
   output logic                      multi_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] HELD     = 2'd2;
   localparam logic [1:0] RELEASE  = 2'd3;

   logic [3:0]    raw;
   logic [3:0]    s_meta;
   logic [3:0]    s;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic [1:0]    cap;
   logic [1:0]    enc;
   logic [3:0]    cap_onehot;
   logic          single;
   logic          any;

   assign raw = {button_color_yellow, button_color_blue, button_color_red, button_color_green};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_meta <= 4'b0000;
         s      <= 4'b0000;
      end else begin
         s_meta <= raw;
         s      <= s_meta;
      end
   end

   assign any         = (s != 4'b0000);
   assign single      = any && ((s & (s - 4'd1)) == 4'b0000);
   assign multi_press = any && !single;
   assign cap_onehot  = 4'b0001 << cap;
   assign cnt_inc     = cnt + CNT_ONE;

   always_comb begin
      enc = 2'd0;
      case (s)
         4'b0010: enc = 2'd1;
         4'b0100: enc = 2'd2;
         4'b1000: enc = 2'd3;
         default: enc = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         cap         <= 2'd0;
         color_valid <= 1'b0;
         color_code  <= '0;
      end else begin
         color_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (enable && single) begin
                  cap <= enc;
                  cnt <= CNT_ONE;
                  // A one-sample debounce completes on the capture itself.
                  if (DEBOUNCE_CYCLES == 1) begin
                     color_valid <= 1'b1;
                     color_code  <= COLOR_CODEFY_W'(enc);
                     state       <= HELD;
                  end else begin
                     state <= DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (!any) begin
                  state <= IDLE;
               end else if (enable && s == cap_onehot) begin
                  cnt <= cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     color_valid <= 1'b1;
                     color_code  <= COLOR_CODEFY_W'(cap);
                     state       <= HELD;
                  end
               end else begin
                  // Dirty press: park in HELD so it can never fire late.
                  state <= HELD;
               end
            end
            HELD: begin
               if (!any) begin
                  cnt   <= CNT_ONE;
                  state <= (DEBOUNCE_CYCLES == 1) ? IDLE : RELEASE;
               end
            end
            RELEASE: begin
               if (any) begin
                  state <= HELD;
               end else if (cnt_inc >= CNT_DONE) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_genius_button_decoder.sv
// Bench for genius_button_decoder: hand-computed vector table, corner sequences and random stimulus
// compared cycle by cycle against a press/lock reference model.
`timescale 1ns/1ps
module tb_genius_button_decoder;

   localparam int DC = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] raw = 4'b0000;
   logic       enable = 1'b0;
   logic       color_valid;
   logic [1:0] color_code;
   logic       multi_press;

   genius_button_decoder #(.COLOR_CODEFY_W(2), .DEBOUNCE_CYCLES(DC)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .button_color_green  (raw[0]),
      .button_color_red    (raw[1]),
      .button_color_blue   (raw[2]),
      .button_color_yellow (raw[3]),
      .enable              (enable),
      .color_valid         (color_valid),
      .color_code          (color_code),
      .multi_press         (multi_press)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int pulses = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: "armed" means a new press may be accepted; a candidate button must be
   // seen DC times in a row with enable high; after any lock, DC zero samples re-arm.
   bit         m_armed;
   int         m_cand, m_run, m_zero, m_code;
   bit         m_cv, m_mp;
   logic [3:0] m_p1, m_s;

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_armed = 1; m_cand = -1; m_run = 0; m_zero = 0; m_code = 0;
      m_cv = 0; m_mp = 0; m_p1 = 4'b0000; m_s = 4'b0000;
   endtask

   task automatic model_step(input logic [3:0] r, input bit en);
      m_cv = 0;
      if (m_armed) begin
         if (m_cand < 0) begin
            if (en && $countones(m_s) == 1) begin
               m_cand = idx_of(m_s);
               m_run  = 1;
            end
         end else if (m_s == 4'b0000) begin
            m_cand = -1;
         end else if (en && m_s == (4'b0001 << m_cand)) begin
            m_run++;
         end else begin
            m_armed = 0; m_cand = -1; m_zero = 0;
         end
         if (m_cand >= 0 && m_run >= DC) begin
            m_cv = 1; m_code = m_cand; m_armed = 0; m_cand = -1; m_zero = 0;
         end
      end else if (m_s == 4'b0000) begin
         m_zero++;
         if (m_zero >= DC) m_armed = 1;
      end else begin
         m_zero = 0;
      end
      m_s  = m_p1;
      m_p1 = r;
      m_mp = ($countones(m_s) > 1);
   endtask

   // One cycle: drive at negedge, model the edge, compare at the next negedge.
   task automatic tick(input logic [3:0] r, input bit en);
      raw = r;
      enable = en;
      @(posedge clk);
      model_step(r, en);
      @(negedge clk);
      chk("model_valid", color_valid, m_cv);
      chk("model_code", color_code, m_code);
      chk("model_multi", multi_press, m_mp);
      if (color_valid) pulses++;
   endtask

   typedef struct {
      logic [3:0] raw;
      bit         en;
      bit         cv;
      int         code;
      bit         mp;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int n, input logic [3:0] r, input bit en, input bit cv,
                      input int code, input bit mp);
      vec_t v;
      v.raw = r; v.en = en; v.cv = cv; v.code = code; v.mp = mp;
      repeat (n) tbl.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int at;
      logic [3:0] r;
      bit en;
      int len, k;

      model_reset();
      rst_n = 1'b0;
      raw = 4'b0011;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_valid", color_valid, 0);
      chk("reset_code", color_code, 0);
      chk("reset_multi", multi_press, 0);
      raw = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;

      // Green, red, blue, yellow presses: strobe on the 4th row of each press.
      add(3, 4'b0001, 1, 0, 0, 0); add(1, 4'b0000, 1, 1, 0, 0); add(4, 4'b0000, 1, 0, 0, 0);
      add(3, 4'b0010, 1, 0, 0, 0); add(1, 4'b0000, 1, 1, 1, 0); add(4, 4'b0000, 1, 0, 1, 0);
      add(3, 4'b0100, 1, 0, 1, 0); add(1, 4'b0000, 1, 1, 2, 0); add(4, 4'b0000, 1, 0, 2, 0);
      add(3, 4'b1000, 1, 0, 2, 0); add(1, 4'b0000, 1, 1, 3, 0); add(4, 4'b0000, 1, 0, 3, 0);
      // Single-edge bounce.
      add(1, 4'b0100, 1, 0, 3, 0); add(5, 4'b0000, 1, 0, 3, 0);
      // Green+red together: multi_press follows s, one cycle behind raw.
      add(1, 4'b0011, 1, 0, 3, 0); add(3, 4'b0011, 1, 0, 3, 1);
      add(1, 4'b0000, 1, 0, 3, 1); add(5, 4'b0000, 1, 0, 3, 0);
      // Yellow with enable low.
      add(3, 4'b1000, 0, 0, 3, 0); add(3, 4'b0000, 0, 0, 3, 0); add(2, 4'b0000, 1, 0, 3, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         tick(tbl[i].raw, tbl[i].en);
         chk($sformatf("tbl%0d_valid", i), color_valid, tbl[i].cv);
         chk($sformatf("tbl%0d_code", i), color_code, tbl[i].code);
         chk($sformatf("tbl%0d_multi", i), multi_press, tbl[i].mp);
      end

      // Long hold, 1-cycle gap re-press, then a 3-cycle release and a real re-press.
      pulses = 0;
      repeat (50) tick(4'b0100, 1);
      tick(4'b0000, 1);
      repeat (10) tick(4'b0100, 1);
      repeat (3) tick(4'b0000, 1);
      chk("long_hold_pulses", pulses, 1);
      pulses = 0;
      repeat (4) tick(4'b0100, 1);
      repeat (6) tick(4'b0000, 1);
      chk("repress_pulses", pulses, 1);
      chk("repress_code", color_code, 2);

      // Enable dropped mid-debounce, restored while yellow is still held.
      pulses = 0;
      repeat (3) tick(4'b1000, 1);
      tick(4'b1000, 0);
      repeat (10) tick(4'b1000, 1);
      repeat (6) tick(4'b0000, 1);
      chk("enable_drop_pulses", pulses, 0);

      // Reset asserted mid-debounce with green held; outputs clear without a clock edge.
      repeat (3) tick(4'b0001, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_valid", color_valid, 0);
      chk("async_reset_code", color_code, 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      at = -1;
      for (int i = 0; i < 8; i++) begin
         tick(4'b0001, 1);
         if (color_valid && at < 0) at = i;
      end
      repeat (6) tick(4'b0000, 1);
      chk("post_reset_pulse_edge", at, 3);
      chk("post_reset_pulses", pulses, 1);

      // Random segments of held values against the model.
      for (int seg = 0; seg < 1500; seg++) begin
         len = $urandom_range(1, 6);
         k = $urandom_range(0, 9);
         if (k < 3) r = 4'b0000;
         else if (k < 8) r = 4'b0001 << $urandom_range(0, 3);
         else r = 4'($urandom_range(0, 15));
         en = ($urandom_range(0, 7) != 0);
         repeat (len) tick(r, en);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
